// File: rtl/softmax_row_max_sub.sv
// ----------------------------------------------------------------------------
// softmax_row_max_sub
//
// Sits after the BRAM row reader in the softmax32 datapath. When the reader
// pulses i_start, the whole signed row is captured. The row maximum is then
// found with a sequential scan of N cycles. Finally x[i] - max is streamed
// for i = 0..N-1 over a valid/ready handshake. Every streamed value is <= 0,
// which keeps the input range of the following exp stage bounded.
//
// Ports
//   clk      : clock; all logic is on the rising edge
//   rst      : synchronous reset, active-high (aborts a row without done)
//   i_start  : one-cycle row-ready pulse; honoured only in IDLE
//   i_data   : N packed signed elements; element i is i_data[i*BIT_WIDTH +: BIT_WIDTH]
//   o_busy   : high in every state except IDLE
//   o_valid  : output beat valid (EMIT state)
//   i_ready  : downstream accepts the current beat
//   o_data   : signed x[o_idx] - max, one bit wider than the input
//   o_idx    : element index of the current beat
//   o_last   : high on the beat with o_idx = N-1
//   o_max    : signed row maximum, stable from the first beat until the next start
//   done     : one-cycle pulse after the last beat has been accepted
// ----------------------------------------------------------------------------
module softmax_row_max_sub #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 32,
  parameter int IDX_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [BIT_WIDTH*N-1:0]      i_data,
  output logic                        o_busy,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [BIT_WIDTH:0]   o_data,
  output logic [IDX_WIDTH-1:0]        o_idx,
  output logic                        o_last,
  output logic signed [BIT_WIDTH-1:0] o_max,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    EMIT    = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0]        LAST_IDX = IDX_WIDTH'(N - 1);
  // Most negative representable value: any element compares >= to it, so the
  // first element always becomes the running max.
  localparam logic signed [BIT_WIDTH-1:0] MIN_VAL  = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  state_t                      state_reg, state_next;
  logic [IDX_WIDTH-1:0]        cnt_reg;
  logic signed [BIT_WIDTH-1:0] max_reg;
  logic signed [BIT_WIDTH-1:0] row_reg [N];
  logic signed [BIT_WIDTH-1:0] in_elem [N];

  logic                        load_row;
  logic                        cnt_at_last;
  logic                        emit_active;
  logic                        transfer;
  logic signed [BIT_WIDTH-1:0] cur_elem;
  logic signed [BIT_WIDTH:0]   diff;

  // Unpack the flat input bus into an element array.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign in_elem[gi] = i_data[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  assign load_row    = (state_reg == IDLE) && i_start;
  assign cnt_at_last = (cnt_reg == LAST_IDX);
  assign emit_active = (state_reg == EMIT);
  assign transfer    = emit_active && i_ready;
  assign cur_elem    = row_reg[cnt_reg];

  // Both operands sign-extended by one bit: the difference spans
  // [-(2^BIT_WIDTH - 1), 0] and therefore cannot wrap.
  assign diff = {cur_elem[BIT_WIDTH-1], cur_elem} - {max_reg[BIT_WIDTH-1], max_reg};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start)                 state_next = SCAN;
      SCAN:    if (cnt_at_last)             state_next = EMIT;
      EMIT:    if (transfer && cnt_at_last) state_next = DONE_ST;
      DONE_ST:                              state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Row buffer: captured only when a start is accepted, so a start pulse
  // arriving while busy cannot corrupt the row being processed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        row_reg[i] <= '0;
      end
    end else if (load_row) begin
      for (int i = 0; i < N; i++) begin
        row_reg[i] <= in_elem[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Index counter and running maximum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      max_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            cnt_reg <= '0;
            max_reg <= MIN_VAL;
          end
        end
        SCAN: begin
          // Strict compare keeps the first occurrence on ties.
          if (cur_elem > max_reg) begin
            max_reg <= cur_elem;
          end
          cnt_reg <= cnt_at_last ? '0 : cnt_reg + 1'b1;
        end
        EMIT: begin
          if (transfer) begin
            cnt_reg <= cnt_at_last ? '0 : cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only; i_ready never reaches
  // o_valid combinationally. max_reg holds its value after the row, so
  // o_max stays valid until the next start re-seeds it.
  // --------------------------------------------------------------------------
  assign o_busy  = (state_reg != IDLE);
  assign o_valid = emit_active;
  assign o_data  = emit_active ? diff : '0;
  assign o_idx   = emit_active ? cnt_reg : '0;
  assign o_last  = emit_active && cnt_at_last;
  assign o_max   = max_reg;
  assign done    = (state_reg == DONE_ST);

endmodule

// File: tb/tb_softmax_row_max_sub.sv
// ----------------------------------------------------------------------------
// tb_softmax_row_max_sub
//
// Scoreboard bench. The stimulus side computes the expected beats of each row
// from its own model (row max, x[i] - max, last flag) and pushes them into a
// queue; an independent monitor pops and compares on every accepted beat,
// checks stability while stalled, and counts done pulses.
// ----------------------------------------------------------------------------
module tb_softmax_row_max_sub;

  localparam int BW  = 16;
  localparam int N   = 32;
  localparam int IW  = 5;

  typedef logic signed [BW-1:0] row_t [N];

  typedef struct {
    longint data;
    int     idx;
    int     last;
    longint mx;
  } beat_t;

  logic                 clk;
  logic                 rst;
  logic                 i_start;
  logic [BW*N-1:0]      i_data;
  logic                 o_busy;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [BW:0]   o_data;
  logic [IW-1:0]        o_idx;
  logic                 o_last;
  logic signed [BW-1:0] o_max;
  logic                 done;

  softmax_row_max_sub #(
    .BIT_WIDTH (BW),
    .N         (N),
    .IDX_WIDTH (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_data  (i_data),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_idx   (o_idx),
    .o_last  (o_last),
    .o_max   (o_max),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  beat_t sb [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BW*N-1:0] pack(input row_t r);
    logic [BW*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*BW +: BW] = r[i];
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " o_busy"},  longint'(o_busy),  0);
    chk({tag, " o_valid"}, longint'(o_valid), 0);
    chk({tag, " o_data"},  longint'(o_data),  0);
    chk({tag, " o_idx"},   longint'(o_idx),   0);
    chk({tag, " o_last"},  longint'(o_last),  0);
    chk({tag, " o_max"},   longint'(o_max),   0);
    chk({tag, " done"},    longint'(done),    0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares every accepted beat against the scoreboard and checks
  // that a stalled beat is held unchanged.
  // --------------------------------------------------------------------------
  logic               prev_stall = 1'b0;
  logic signed [BW:0] prev_data;
  logic [IW-1:0]      prev_idx;
  logic               prev_last;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall o_valid held", longint'(o_valid), 1);
        chk("stall o_data held",  longint'(o_data),  longint'(prev_data));
        chk("stall o_idx held",   longint'(o_idx),   longint'(prev_idx));
        chk("stall o_last held",  longint'(o_last),  longint'(prev_last));
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected beat idx", longint'(o_idx), -1);
        end else begin
          e = sb.pop_front();
          $display("beat idx=%0d data=%0d last=%0d max=%0d", o_idx, o_data, o_last, o_max);
          chk("beat o_idx",  longint'(o_idx),  longint'(e.idx));
          chk("beat o_data", longint'(o_data), e.data);
          chk("beat o_last", longint'(o_last), longint'(e.last));
          chk("beat o_max",  longint'(o_max),  e.mx);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_idx   = o_idx;
      prev_last  = o_last;
    end
  end

  // --------------------------------------------------------------------------
  // Row driver. ready_mode 0: i_ready tied high, 1: random ~50%.
  // inject: extra start pulses (other data) during SCAN and EMIT.
  // abort_idx >= 0: assert rst when that beat is presented.
  // Cycle k counts negedges after the cycle in which i_start is high.
  // --------------------------------------------------------------------------
  task automatic run_row(input string name, input row_t r, input int ready_mode,
                         input int inject, input int abort_idx,
                         output int first_valid_k, output int done_k);
    longint mx;
    int     k;
    int     d0;
    row_t   other;
    beat_t  e;

    mx = r[0];
    for (int i = 1; i < N; i++) if (r[i] > mx) mx = r[i];
    for (int i = 0; i < N; i++) begin
      e.data = longint'(r[i]) - mx;
      e.idx  = i;
      e.last = (i == N - 1) ? 1 : 0;
      e.mx   = mx;
      sb.push_back(e);
    end
    for (int i = 0; i < N; i++) other[i] = 16'sd30000;

    first_valid_k = -1;
    done_k        = -1;
    d0            = done_cnt;
    k             = 0;

    @(posedge clk); #1;
    i_data  = pack(r);
    i_start = 1'b1;
    i_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);

    for (int it = 0; it < 2000; it++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      if (inject != 0 && (k == 5 || k == 40)) begin
        i_start = 1'b1;
        i_data  = pack(other);
      end
      i_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      k++;
      if (o_valid && first_valid_k < 0) first_valid_k = k;
      if (done) begin
        done_k = k;
        break;
      end
      if (abort_idx >= 0 && o_valid && int'(o_idx) == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        check_all_zero({name, " after abort"});
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk({name, " no done after abort"}, longint'(done_cnt - d0), 0);
        $display("row %s aborted at idx %0d", name, abort_idx);
        return;
      end
    end

    if (done_k < 0) chk({name, " done within budget"}, 0, 1);
    @(negedge clk); #1;
    chk({name, " idle after done (o_busy)"}, longint'(o_busy), 0);
    chk({name, " done is one cycle"},        longint'(done),   0);
    chk({name, " all beats consumed"},       longint'(sb.size()), 0);
    chk({name, " exactly one done"},         longint'(done_cnt - d0), 1);
    $display("row %s: first_valid=%0d done=%0d", name, first_valid_k, done_k);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    row_t r;
    int   fv;
    int   dk;

    rst     = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post-reset idle");

    // Start coinciding with reset is dropped.
    @(posedge clk); #1;
    rst     = 1'b1;
    i_start = 1'b1;
    i_data  = '1;
    @(posedge clk); #1;
    rst     = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk("start during rst ignored (o_busy)", longint'(o_busy), 0);

    // Ascending row: max 31, o_data = i - 31. Start cycle 0; SCAN runs in
    // cycles 1..32, beats in 33..64, done in 65 (2N+2 cycles inclusive).
    for (int i = 0; i < N; i++) r[i] = BW'(i);
    run_row("ascending", r, 0, 0, -1, fv, dk);
    chk("ascending first o_valid cycle", fv, 33);
    chk("ascending done cycle",          dk, 65);

    // All equal: every difference is zero.
    for (int i = 0; i < N; i++) r[i] = -16'sd5;
    run_row("all_minus5", r, 0, 0, -1, fv, dk);

    // Extremes: -32768 - 32767 = -65535 needs the 17th bit.
    for (int i = 0; i < N; i++) r[i] = '0;
    r[0] = -16'sd32768;
    r[7] = 16'sd32767;
    run_row("extremes", r, 0, 0, -1, fv, dk);

    // Back-pressure with random ready on a scrambled row.
    for (int i = 0; i < N; i++) r[i] = BW'((i * 7919) % 2001 - 1000);
    run_row("random_ready", r, 1, 0, -1, fv, dk);

    // Extra start pulses in SCAN and EMIT must be ignored.
    for (int i = 0; i < N; i++) r[i] = BW'(50 - 3 * i);
    run_row("restart_ignored", r, 0, 1, -1, fv, dk);

    // Reset in the middle of EMIT, then a fresh row.
    for (int i = 0; i < N; i++) r[i] = BW'(i * 11 - 200);
    run_row("abort", r, 0, 0, 10, fv, dk);
    for (int i = 0; i < N; i++) r[i] = BW'(100 - 3 * i);
    run_row("after_abort", r, 0, 0, -1, fv, dk);
    chk("after_abort first o_valid cycle", fv, 33);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
